// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding and sizing helpers for the async-SRAM controller.
package sram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_RD,
    S_RSP,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } sram_state_t;

  localparam int WAIT_MAX = 15;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_bus_ctrl_if.sv
// sram_bus_ctrl_if: request/response handshake plus SRAM strobe/address pins.
interface sram_bus_ctrl_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  localparam int LANES = lanes(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LANES-1:0]  req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              CE;
  logic              OE;
  logic              WE;
  logic [LANES-1:0]  BE;
  logic [ADDR_W-1:0] ADDR;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata,
    input  CE, OE, WE, BE, ADDR
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata,
    output CE, OE, WE, BE, ADDR
  );

endinterface

// File: rtl/sram_tristate.sv
// sram_tristate: the single point where the SRAM data bus is released to 'z.
module sram_tristate #(
  parameter int DATA_W = 16
) (
  input  logic              drive_en,
  input  logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] in_data,
  inout  wire  [DATA_W-1:0] Data
);

  assign Data    = drive_en ? out_data : 'z;
  assign in_data = Data;

endmodule

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: valid/ready requests to async-SRAM CE/OE/WE/BE strobe sequences.
// Optional one-cycle write-to-read bus turnaround when SRAM_TURNAROUND_EN is defined.
module sram_bus_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  sram_bus_ctrl_if.slave   bus,
  inout  wire [DATA_W-1:0] Data
);

  localparam int LANES = lanes(DATA_W);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC - 1);

  if (WAIT_CYC < 1 || WAIT_CYC > WAIT_MAX || (DATA_W % 8) != 0) begin : g_bad_param
    $error("sram_bus_ctrl: WAIT_CYC must be 1..15 and DATA_W a multiple of 8");
  end

  sram_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] din;
  logic              turn;
  logic              drive_en;
  logic              ce, oe, we, rsp_valid;
  logic [LANES-1:0]  be_n;

`ifdef SRAM_TURNAROUND_EN
  logic last_wr_q, last_wr_d;

  always_comb begin
    last_wr_d = last_wr_q;
    if (state_q == S_IDLE && bus.req_valid)
      last_wr_d = bus.req_we;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) last_wr_q <= 1'b0;
    else       last_wr_q <= last_wr_d;
  end

  assign turn = last_wr_q;
`else
  assign turn = 1'b0;
`endif

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < LANES; i++)
      lane_mask[8*i +: 8] = {8{be_q[i]}};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = WAIT_LD;
          if (bus.req_we) state_d = S_WR_SETUP;
          else if (turn)  state_d = S_TURN;
          else            state_d = S_RD;
        end
      end
      S_TURN: begin
        state_d = S_RD;
        cnt_d   = WAIT_LD;
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d = din & lane_mask;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RSP:      state_d = S_IDLE;
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WAIT_LD;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = S_WR_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WR_HOLD:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    ce        = 1'b1;
    oe        = 1'b1;
    we        = 1'b1;
    be_n      = '1;
    drive_en  = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_RD: begin
        ce   = 1'b0;
        oe   = 1'b0;
        be_n = ~be_q;
      end
      S_RSP: rsp_valid = 1'b1;
      S_WR_SETUP: begin
        ce       = 1'b0;
        be_n     = ~be_q;
        drive_en = 1'b1;
      end
      S_WR_PULSE: begin
        ce       = 1'b0;
        we       = 1'b0;
        be_n     = ~be_q;
        drive_en = 1'b1;
      end
      S_WR_HOLD: begin
        ce        = 1'b0;
        be_n      = ~be_q;
        drive_en  = 1'b1;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE) & ~Reset;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.CE        = ce;
  assign bus.OE        = oe;
  assign bus.WE        = we;
  assign bus.BE        = be_n;
  assign bus.ADDR      = addr_q;

  sram_tristate #(.DATA_W(DATA_W)) u_tri (
    .drive_en (drive_en),
    .out_data (wdata_q),
    .in_data  (din),
    .Data     (Data)
  );

endmodule
